regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised successor to the pipeline's integer register file: configurable data width, depth and number of read ports, with a per-register pending-write scoreboard. The decode stage marks a destination register pending at issue; writeback clears it. Read ports return data together with a busy flag so hazard logic can stall without tracking destinations itself. Register 0 is hardwired to zero, matching RV32I.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers; power of two, at least 2
- NUM_RD, 2, number of read ports, 1..4
- AW (localparam), $clog2(DEPTH), address width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- we  in  1  write enable, writeback stage
- wr_addr  in  AW  write address
- wr_data  in  DATA_W  write data
- rd_addr  in  NUM_RD*AW  read addresses; port i is bits [i*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  read data; port i is bits [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  pending flag of each read address
- iss_valid  in  1  issue marks a destination pending
- iss_addr  in  AW  destination of the issuing instruction
- pend_cnt  out  AW+1  number of pending registers
- all_clear  out  1  high when pend_cnt == 0

## Operation
- Storage: DEPTH×DATA_W flops plus DEPTH pending bits, pend[i].
- Write: at a rising edge with we=1 and wr_addr≠0, reg[wr_addr] ← wr_data and pend[wr_addr] is cleared.
- Issue: at a rising edge with iss_valid=1 and iss_addr≠0, pend[iss_addr] is set.
- Issue and write to the same address in one cycle: the set wins, because the new producer supersedes the old one. The data write still occurs.
- Address 0:
  - Writes and issues to address 0 are ignored.
  - rd_data is 0 and rd_busy is 0 whenever rd_addr selects 0.
- Reads: combinational. rd_data[i] = reg[rd_addr[i]] and rd_busy[i] = pend[rd_addr[i]], subject to the bypass rule in Configuration.
- Any number of read ports may select the same address.
- pend_cnt:
  - Registered. Updated each edge by (+1 if a pending bit goes 0→1) and (−1 if one goes 1→0).
  - Writes to non-pending registers do not decrement it.
  - It never exceeds DEPTH−1.
  - all_clear = (pend_cnt == 0).

## Timing
- Reset: on any edge with reset=1, all registers, all pend bits and pend_cnt go to 0; we and iss_valid are ignored that cycle.
- Outputs during and after reset:
  - rd_data reads 0 for every address.
  - rd_busy is 0 on every port.
  - pend_cnt is 0 and all_clear is 1.
- Reset mid-operation discards all pending state; no write completes in the reset cycle.
- Write-to-read latency:
  - 1 cycle: the data is visible on the cycle after the write edge.
  - 0 cycles with bypass compiled in.
- Issue-to-busy latency: 1 cycle, with no bypass of the set.
- Ports have no handshake. we and iss_valid are single-cycle qualifiers, and addresses are sampled only when their qualifier is high.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read port whose rd_addr equals wr_addr (≠0) while we=1 returns wr_data in the same cycle.
  - rd_busy for that port is 0 unless iss_valid=1 with iss_addr equal to the same address.
- REGFILE_BYPASS_EN undefined:
  - rd_data and rd_busy reflect the stored state only.
  - A same-cycle write is visible on the next cycle.

## Structure
- Shared package rv_regfile_pkg holds:
  - default DATA_W and DEPTH constants
  - the REG_ZERO address constant
  - a function computing AW
- One sub-module, regfile_sb_pend, contains the pending-bit array, the set/clear priority logic and pend_cnt.
- regfile_sb instantiates it once. Storage, read muxes and bypass remain at the top level.

## Test plan
- Reset check: write reg5=0xDEADBEEF, assert reset for one cycle, read port 0 at 5 → rd_data=0, rd_busy=0, pend_cnt=0, all_clear=1.
- Issue then write: issue 7; next cycle rd_busy=1 and pend_cnt=1. Write reg7=0x1234 → on the following cycle rd_data=0x1234, rd_busy=0, pend_cnt=0.
- Same-cycle issue and write to 9 while 9 is pending → pend stays 1, reg9 updated, pend_cnt unchanged.
- Address 0: issue 0 and write 0 with 0xFFFFFFFF → all ports reading 0 return 0 with busy 0, and pend_cnt=0.
- Bypass, with REGFILE_BYPASS_EN defined: we=1, wr_addr=3, wr_data=0xA5A5A5A5, both ports reading 3 → both return 0xA5A5A5A5 in the same cycle. Without the macro, both return the old value, then the new value one cycle later.
- Parameter sweep: DATA_W=16, DEPTH=8, NUM_RD=3. Issue all of 1..7 → pend_cnt=7. Write all of 1..7 → pend_cnt=0, all_clear=1.

Source files
------------

// File: rtl/rv_regfile_pkg.sv
// Shared constants and helpers for the scoreboarded integer register file.
package rv_regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int REG_ZERO   = 0;

  function automatic int calc_aw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/regfile_sb_pend.sv
// Pending-write scoreboard: one bit per register plus a running count of set bits.
module regfile_sb_pend
  import rv_regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = calc_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_addr,
  output logic [DEPTH-1:0] pend,
  output logic [AW:0]      pend_cnt
);
  localparam int CW = AW + 1;

  logic             set_en, clr_en, inc, dec;
  logic [DEPTH-1:0] pend_nxt;
  logic [CW-1:0]    cnt_nxt;

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    set_en   = iss_valid && (iss_addr != AW'(REG_ZERO));
    clr_en   = we && (wr_addr != AW'(REG_ZERO));
    pend_nxt = pend;
    if (clr_en) pend_nxt[wr_addr] = 1'b0;
    if (set_en) pend_nxt[iss_addr] = 1'b1;
    inc      = set_en && !pend[iss_addr];
    dec      = clr_en && pend[wr_addr] && !(set_en && (iss_addr == wr_addr));
    cnt_nxt  = pend_cnt + CW'(inc) - CW'(dec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with per-register pending scoreboard, x0 hardwired to zero.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_sb
  import rv_regfile_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int NUM_RD = 2,
  localparam int AW     = calc_aw(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_addr,
  output logic [AW:0]              pend_cnt,
  output logic                     all_clear
);
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             pend;
  logic [AW:0]                  cnt_q;

  regfile_sb_pend #(.DEPTH(DEPTH), .AW(AW)) u_pend (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .pend      (pend),
    .pend_cnt  (cnt_q)
  );

  always_ff @(posedge clk) begin
    if (reset)
      mem <= '0;
    else if (we && (wr_addr != AW'(REG_ZERO)))
      mem[wr_addr] <= wr_data;
  end

  // Outputs are forced to their reset values while reset is held, not only after the edge.
  assign pend_cnt  = reset ? '0 : cnt_q;
  assign all_clear = (pend_cnt == '0);

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = rd_addr[i*AW +: AW];

    always_comb begin
      d = mem[a];
      b = pend[a];
`ifdef REGFILE_BYPASS_EN
      if (we && (wr_addr != AW'(REG_ZERO)) && (a == wr_addr)) begin
        d = wr_data;
        b = iss_valid && (iss_addr == a);
      end
`endif
      if (reset || (a == AW'(REG_ZERO))) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = d;
    assign rd_busy[i]                  = b;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table, corner sequences, random vs. model.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        reset;
  // default-parameter instance
  logic        we, iss_valid;
  logic [4:0]  wr_addr, iss_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [5:0]  pend_cnt;
  logic        all_clear;
  // sweep instance: DATA_W=16, DEPTH=8, NUM_RD=3
  logic        p_we, p_iss_valid;
  logic [2:0]  p_wr_addr, p_iss_addr;
  logic [15:0] p_wr_data;
  logic [8:0]  p_rd_addr;
  logic [47:0] p_rd_data;
  logic [2:0]  p_rd_busy;
  logic [3:0]  p_pend_cnt;
  logic        p_all_clear;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .pend_cnt(pend_cnt), .all_clear(all_clear)
  );

  regfile_sb #(.DATA_W(16), .DEPTH(8), .NUM_RD(3)) dut_p (
    .clk(clk), .reset(reset), .we(p_we), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
    .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_busy(p_rd_busy),
    .iss_valid(p_iss_valid), .iss_addr(p_iss_addr), .pend_cnt(p_pend_cnt), .all_clear(p_all_clear)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // one operation on the edge, then qualifiers drop
  task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic iv, input logic [4:0] ia);
    we = w; wr_addr = wa; wr_data = wd; iss_valid = iv; iss_addr = ia;
    @(posedge clk); #1;
    we = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic chk_ports(input string tag, input logic [31:0] d0, input logic b0,
                           input logic [31:0] d1, input logic b1, input logic [5:0] cnt);
    chk({tag, ".d0"}, rd_data[31:0], d0);
    chk({tag, ".b0"}, rd_busy[0], b0);
    chk({tag, ".d1"}, rd_data[63:32], d1);
    chk({tag, ".b1"}, rd_busy[1], b1);
    chk({tag, ".cnt"}, pend_cnt, cnt);
    chk({tag, ".clr"}, all_clear, cnt == 0);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  ra0, ra1;
    logic [31:0] ed0;
    logic        eb0;
    logic [31:0] ed1;
    logic        eb1;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t vecs[10];

  // reference model
  logic [31:0] m_reg[32];
  logic [31:0] m_pend;

  initial begin
    #1_000_000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ed;
    logic        eb;
    logic [4:0]  a;
    logic [31:0] byp_d;
    logic        byp_b;

    vecs[0] = '{"idle",      0, 0, 0,            0, 0, 0, 5,  0, 0, 0, 0, 0};
    vecs[1] = '{"wr5",       1, 5, 32'hDEADBEEF, 0, 0, 5, 0,  32'hDEADBEEF, 0, 0, 0, 0};
    vecs[2] = '{"iss7",      0, 0, 0,            1, 7, 7, 5,  0, 1, 32'hDEADBEEF, 0, 1};
    vecs[3] = '{"wr7",       1, 7, 32'h1234,     0, 0, 7, 7,  32'h1234, 0, 32'h1234, 0, 0};
    vecs[4] = '{"iss9",      0, 0, 0,            1, 9, 9, 0,  0, 1, 0, 0, 1};
    vecs[5] = '{"isswr9",    1, 9, 32'hAAAA5555, 1, 9, 9, 9,  32'hAAAA5555, 1, 32'hAAAA5555, 1, 1};
    vecs[6] = '{"zero",      1, 0, 32'hFFFFFFFF, 1, 0, 0, 0,  0, 0, 0, 0, 1};
    vecs[7] = '{"wr12np",    1, 12, 32'h1,       0, 0, 12, 9, 32'h1, 0, 32'hAAAA5555, 1, 1};
    vecs[8] = '{"iss3wr9",   1, 9, 32'h77,       1, 3, 3, 9,  0, 1, 32'h77, 0, 1};
    vecs[9] = '{"wr3",       1, 3, 32'hA0,       0, 0, 3, 3,  32'hA0, 0, 32'hA0, 0, 0};

    we = 0; iss_valid = 0; wr_addr = 0; iss_addr = 0; wr_data = 0; rd_addr = 0;
    p_we = 0; p_iss_valid = 0; p_wr_addr = 0; p_iss_addr = 0; p_wr_data = 0; p_rd_addr = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    rd_addr = {5'd5, 5'd0};
    #1 chk_ports("reset0", 0, 0, 0, 0, 0);

    // vector table
    foreach (vecs[i]) begin
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].iv, vecs[i].ia);
      #1 chk_ports(vecs[i].name, vecs[i].ed0, vecs[i].eb0, vecs[i].ed1, vecs[i].eb1, vecs[i].ecnt);
    end

    // reset mid-operation: pending state discarded, reset-cycle write/issue ignored
    step(1, 5, 32'hDEADBEEF, 1, 4);
    rd_addr = {5'd4, 5'd5};
    #1 chk_ports("prerst", 32'hDEADBEEF, 0, 0, 1, 1);
    reset = 1; we = 1; wr_addr = 5; wr_data = 32'h55; iss_valid = 1; iss_addr = 5;
    #1 chk_ports("inrst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 0; we = 0; iss_valid = 0;
    #1 chk_ports("postrst", 0, 0, 0, 0, 0);

    // bypass corner
    step(1, 3, 32'h11, 0, 0);
    step(0, 0, 0, 1, 3);
    rd_addr = {5'd3, 5'd3};
    we = 1; wr_addr = 3; wr_data = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
    byp_d = 32'hA5A5A5A5; byp_b = 1'b0;
`else
    byp_d = 32'h11; byp_b = 1'b1;
`endif
    #2 chk_ports("byp_same", byp_d, byp_b, byp_d, byp_b, 1);
    @(posedge clk); #1 we = 0;
    #1 chk_ports("byp_next", 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 0);

    // parameter sweep instance
    for (int k = 1; k < 8; k++) begin
      p_iss_valid = 1; p_iss_addr = 3'(k);
      @(posedge clk); #1;
    end
    p_iss_valid = 0;
    p_rd_addr = {3'd7, 3'd4, 3'd1};
    #1;
    chk("sw_cnt7", p_pend_cnt, 7);
    chk("sw_clr0", p_all_clear, 0);
    chk("sw_busy", p_rd_busy, 3'b111);
    for (int k = 1; k < 8; k++) begin
      p_we = 1; p_wr_addr = 3'(k); p_wr_data = 16'h100 + 16'(k);
      @(posedge clk); #1;
    end
    p_we = 0;
    p_rd_addr = {3'd7, 3'd5, 3'd2};
    #1;
    chk("sw_cnt0", p_pend_cnt, 0);
    chk("sw_clr1", p_all_clear, 1);
    chk("sw_busy0", p_rd_busy, 3'b000);
    chk("sw_data", p_rd_data, {16'h107, 16'h105, 16'h102});

    // random phase against model
    reset = 1;
    @(posedge clk); #1 reset = 0;
    foreach (m_reg[i]) m_reg[i] = 0;
    m_pend = 0;
    for (int c = 0; c < 500; c++) begin
      reset     = ($urandom_range(0, 59) == 0);
      we        = 1'($urandom_range(0, 1));
      iss_valid = 1'($urandom_range(0, 1));
      wr_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      iss_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wr_data   = $urandom;
      rd_addr   = {5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1) ? wr_addr : 5'($urandom_range(0, 31))};
      #2;
      for (int p = 0; p < 2; p++) begin
        a = rd_addr[p*5 +: 5];
        ed = m_reg[a];
        eb = m_pend[a];
`ifdef REGFILE_BYPASS_EN
        if (we && wr_addr != 0 && a == wr_addr) begin
          ed = wr_data;
          eb = iss_valid && iss_addr == a;
        end
`endif
        if (reset || a == 0) begin ed = 0; eb = 0; end
        chk($sformatf("rnd%0d.d%0d", c, p), rd_data[p*32 +: 32], ed);
        chk($sformatf("rnd%0d.b%0d", c, p), rd_busy[p], eb);
      end
      chk($sformatf("rnd%0d.cnt", c), pend_cnt, reset ? 6'd0 : 6'($countones(m_pend)));
      @(posedge clk);
      if (reset) begin
        foreach (m_reg[i]) m_reg[i] = 0;
        m_pend = 0;
      end else begin
        if (we && wr_addr != 0) begin m_reg[wr_addr] = wr_data; m_pend[wr_addr] = 1'b0; end
        if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1'b1;
      end
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
